hood_mode_ctrl: RTL and testbench
=================================

Name: hood_mode_ctrl

Overview:
- Kitchen-hood mode controller. Sits between the front-panel buttons and the fan/display stages.
- Conditions the raw mode buttons. Runs the standby/gear/hurricane/self-clean state machine and owns all second-based countdowns.
- Outputs mode_state to the smoker, selfcleaner and display stages, plus the remaining seconds and the mode LEDs.
- Upstream: the on/off controller, which supplies machine_state.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s tick
HURRICANE_S, 60, seconds the hood runs in gear 3 before it drops to gear 2
EXIT_S, 60, seconds the fan keeps running after menu is pressed in gear 3, before standby
CLEAN_S, 180, self-clean duration in seconds

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
machine_state  in  1  1 = powered on (from on/off controller)
menu_btn  in  1  raw button level
mode1_btn  in  1  raw button level
mode2_btn  in  1  raw button level
mode3_btn  in  1  raw button level
mode_self_clean_btn  in  1  raw button level
mode_state  out  3  000 standby, 001 gear1, 010 gear2, 011 gear3, 100 self-clean
exit_wait  out  1  1 while the post-hurricane exit countdown runs
remain_s  out  8  seconds left in the current timed state; 0 otherwise
clean_done  out  1  one-cycle pulse when self-clean completes
led  out  5  one-hot: [0] standby, [1] gear1, [2] gear2, [3] gear3/exit_wait, [4] clean

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state STANDBY, mode_state=000, exit_wait=0, remain_s=0, clean_done=0, led=00001
  - menu_armed=0, hurricane_used=0, tick counter 0
  - all synchroniser flops 0
- Button path, per button: 2-FF synchroniser, then a prev flop, then edge = sync2 & ~prev.
  - A raw level that is stable high before clk edge N acts on state at edge N+3.
- Tick:
  - Counter runs 0..TICK_DIV-1; tick is a 1-cycle pulse on wrap.
  - The counter clears on every state entry, so the first decrement occurs exactly TICK_DIV cycles after entry.
- Priority for simultaneous edges in one cycle: menu > mode3 > mode2 > mode1 > clean. Only the highest-priority edge acts.
- machine_state=0 has the highest priority of all. On the next edge the block goes to STANDBY, clears menu_armed and hurricane_used, and sets remain_s=0. No clean_done pulse is issued.
- States:
  - STANDBY:
    - menu edge sets menu_armed.
    - While armed: mode1 -> GEAR1; mode2 -> GEAR2; mode3 -> GEAR3 if !hurricane_used, otherwise ignored and stays armed; clean -> CLEAN.
    - Any successful selection clears menu_armed. A second menu edge while armed clears it.
  - GEAR1 / GEAR2:
    - mode1/mode2 switch directly between the two gears.
    - mode3 -> GEAR3 if !hurricane_used.
    - menu -> STANDBY immediately.
    - clean is ignored.
  - GEAR3:
    - On entry: hurricane_used=1, remain_s=HURRICANE_S.
    - Each tick decrements remain_s. At a tick with remain_s=1 -> GEAR2, remain_s=0.
    - menu -> EXIT_WAIT. All other buttons are ignored.
  - EXIT_WAIT:
    - mode_state=011, exit_wait=1, remain_s loads EXIT_S and counts down.
    - At a tick with remain_s=1 -> STANDBY. All buttons are ignored.
  - CLEAN:
    - remain_s=CLEAN_S, counts down. All buttons are ignored.
    - At a tick with remain_s=1 -> STANDBY, remain_s=0, clean_done=1 for that cycle.
- remain_s never underflows. It holds 0 in untimed states.
- Outputs are registered and change on the same edge as the state.
- Parameters must satisfy HURRICANE_S, EXIT_S, CLEAN_S in 1..255.

Decomposition:
- Shared package hood_pkg: mode encodings (MODE_STANDBY..MODE_CLEAN), LED one-hot constants, default durations.
- Sub-module btn_edge: synchroniser plus rising-edge pulse, instantiated 5 times. The FSM, tick counter and countdown stay in hood_mode_ctrl.

Test Plan:
All scenarios use TICK_DIV=4, HURRICANE_S=3, EXIT_S=2, CLEAN_S=5.
1. Reset mid-run in GEAR2 (rst=0) -> outputs immediately 000/led 00001/remain_s 0. After release, mode2 with no menu -> stays STANDBY.
2. machine_state=1; menu, then mode2 -> mode_state=010 at edge 3 after mode2 rises; mode1 -> 001; menu -> 000.
3. Armed, then mode3 -> 011, remain_s 3,2,1 at 4-cycle steps, then 010. A later mode3 in GEAR2 -> stays 010 (hurricane_used).
4. GEAR3 then menu -> exit_wait=1, remain_s=2, then 1, then 000, exit_wait=0, after 8 cycles.
5. Armed, then clean -> 100, remain_s 5..1; mode1/menu presses ignored; after 20 cycles -> 000 with one clean_done pulse.
6. Same-cycle menu+mode1 edges in GEAR2 -> STANDBY. machine_state drops during CLEAN -> 000 next edge, no clean_done pulse, hurricane_used cleared (mode3 accepted again).

Source files
------------

// File: rtl/hood_pkg.sv
// Shared definitions for the kitchen-hood mode controller.
//   - FSM state encoding, mode_state encodings, one-hot LED patterns
//   - button index map for the conditioned button vector
//   - default timing parameters
//   - mode_of / led_of: map an FSM state to its mode_state / LED pattern
package hood_pkg;

    localparam int DEF_TICK_DIV    = 100000000;
    localparam int DEF_HURRICANE_S = 60;
    localparam int DEF_EXIT_S      = 60;
    localparam int DEF_CLEAN_S     = 180;

    localparam int NUM_BTN   = 5;
    localparam int BTN_MENU  = 0;
    localparam int BTN_MODE1 = 1;
    localparam int BTN_MODE2 = 2;
    localparam int BTN_MODE3 = 3;
    localparam int BTN_CLEAN = 4;

    localparam logic [2:0] MODE_STANDBY = 3'b000;
    localparam logic [2:0] MODE_GEAR1   = 3'b001;
    localparam logic [2:0] MODE_GEAR2   = 3'b010;
    localparam logic [2:0] MODE_GEAR3   = 3'b011;
    localparam logic [2:0] MODE_CLEAN   = 3'b100;

    localparam logic [4:0] LED_STANDBY = 5'b00001;
    localparam logic [4:0] LED_GEAR1   = 5'b00010;
    localparam logic [4:0] LED_GEAR2   = 5'b00100;
    localparam logic [4:0] LED_GEAR3   = 5'b01000;
    localparam logic [4:0] LED_CLEAN   = 5'b10000;

    typedef enum logic [2:0] {
        ST_STANDBY,
        ST_GEAR1,
        ST_GEAR2,
        ST_GEAR3,
        ST_EXIT_WAIT,
        ST_CLEAN
    } state_e;

    // EXIT_WAIT shows as gear 3: the fan is still running at full speed.
    function automatic logic [2:0] mode_of(state_e s);
        case (s)
            ST_GEAR1:     mode_of = MODE_GEAR1;
            ST_GEAR2:     mode_of = MODE_GEAR2;
            ST_GEAR3:     mode_of = MODE_GEAR3;
            ST_EXIT_WAIT: mode_of = MODE_GEAR3;
            ST_CLEAN:     mode_of = MODE_CLEAN;
            default:      mode_of = MODE_STANDBY;
        endcase
    endfunction

    function automatic logic [4:0] led_of(state_e s);
        case (s)
            ST_GEAR1:     led_of = LED_GEAR1;
            ST_GEAR2:     led_of = LED_GEAR2;
            ST_GEAR3:     led_of = LED_GEAR3;
            ST_EXIT_WAIT: led_of = LED_GEAR3;
            ST_CLEAN:     led_of = LED_CLEAN;
            default:      led_of = LED_STANDBY;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-FF synchroniser, previous-level flop, registered
// rising-edge pulse.
//   clk, rst (async, active-low)
//   btn_raw : raw asynchronous button level
//   edge_o  : one-cycle pulse, high after the third clk edge that sees the
//             button high, so the consumer acts on the fourth edge
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic edge_o
);

    logic sync1_q, sync2_q, prev_q, pls_q;
    logic pls_d;

    always_comb pls_d = sync2_q & ~prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pls_q   <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pls_q   <= pls_d;
        end
    end

    assign edge_o = pls_q;

endmodule

// File: rtl/hood_mode_ctrl.sv
// Kitchen-hood mode controller: conditions the mode buttons, runs the
// standby / gear / hurricane / exit-wait / self-clean FSM and owns the
// 1 s tick and the remaining-seconds countdown.
//   clk, rst (async, active-low)
//   machine_state        : 1 = powered on
//   menu/mode1/mode2/mode3/mode_self_clean_btn : raw button levels
//   mode_state  : 000 standby, 001..011 gears, 100 self-clean
//   exit_wait   : post-hurricane run-down active
//   remain_s    : seconds left in timed states, 0 otherwise
//   clean_done  : one-cycle pulse at the end of self-clean
//   led         : one-hot mode LEDs
module hood_mode_ctrl import hood_pkg::*; #(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int HURRICANE_S = DEF_HURRICANE_S,
    parameter int EXIT_S      = DEF_EXIT_S,
    parameter int CLEAN_S     = DEF_CLEAN_S
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       machine_state,
    input  logic       menu_btn,
    input  logic       mode1_btn,
    input  logic       mode2_btn,
    input  logic       mode3_btn,
    input  logic       mode_self_clean_btn,
    output logic [2:0] mode_state,
    output logic       exit_wait,
    output logic [7:0] remain_s,
    output logic       clean_done,
    output logic [4:0] led
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (HURRICANE_S < 1 || HURRICANE_S > 255 || EXIT_S < 1 || EXIT_S > 255 ||
        CLEAN_S < 1 || CLEAN_S > 255 || TICK_DIV < 1) begin : g_bad_param
        $error("hood_mode_ctrl: durations must be 1..255 and TICK_DIV >= 1");
    end

    logic [NUM_BTN-1:0] btn_raw, btn_pls;

    assign btn_raw = {mode_self_clean_btn, mode3_btn, mode2_btn, mode1_btn, menu_btn};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_edge u_btn (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[i]),
            .edge_o (btn_pls[i])
        );
    end

    state_e        state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    remain_q, remain_d;
    logic          armed_q, armed_d;
    logic          hur_used_q, hur_used_d;
    logic          done_q, done_d;
    logic [2:0]    mode_q, mode_d;
    logic [4:0]    led_q, led_d;
    logic          exit_q, exit_d;
    logic          tick;

    assign tick = (tick_cnt_q == CW'(TICK_DIV - 1));

    // State register (all flops of the block)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_STANDBY;
            tick_cnt_q <= '0;
            remain_q   <= '0;
            armed_q    <= 1'b0;
            hur_used_q <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= MODE_STANDBY;
            led_q      <= LED_STANDBY;
            exit_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            remain_q   <= remain_d;
            armed_q    <= armed_d;
            hur_used_q <= hur_used_d;
            done_q     <= done_d;
            mode_q     <= mode_d;
            led_q      <= led_d;
            exit_q     <= exit_d;
        end
    end

    // Next-state logic. The if/else chains give menu > mode3 > mode2 >
    // mode1 > clean: a higher edge that is ignored still masks lower ones.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        armed_d    = armed_q;
        hur_used_d = hur_used_q;
        done_d     = 1'b0;

        if (!machine_state) begin
            state_d    = ST_STANDBY;
            remain_d   = '0;
            armed_d    = 1'b0;
            hur_used_d = 1'b0;
        end else begin
            case (state_q)
                ST_STANDBY: begin
                    if (btn_pls[BTN_MENU]) begin
                        armed_d = ~armed_q;
                    end else if (armed_q) begin
                        if (btn_pls[BTN_MODE3]) begin
                            if (!hur_used_q) begin
                                state_d    = ST_GEAR3;
                                remain_d   = 8'(HURRICANE_S);
                                hur_used_d = 1'b1;
                                armed_d    = 1'b0;
                            end
                        end else if (btn_pls[BTN_MODE2]) begin
                            state_d = ST_GEAR2;
                            armed_d = 1'b0;
                        end else if (btn_pls[BTN_MODE1]) begin
                            state_d = ST_GEAR1;
                            armed_d = 1'b0;
                        end else if (btn_pls[BTN_CLEAN]) begin
                            state_d  = ST_CLEAN;
                            remain_d = 8'(CLEAN_S);
                            armed_d  = 1'b0;
                        end
                    end
                end
                ST_GEAR1, ST_GEAR2: begin
                    if (btn_pls[BTN_MENU]) begin
                        state_d = ST_STANDBY;
                    end else if (btn_pls[BTN_MODE3]) begin
                        if (!hur_used_q) begin
                            state_d    = ST_GEAR3;
                            remain_d   = 8'(HURRICANE_S);
                            hur_used_d = 1'b1;
                        end
                    end else if (btn_pls[BTN_MODE2]) begin
                        state_d = ST_GEAR2;
                    end else if (btn_pls[BTN_MODE1]) begin
                        state_d = ST_GEAR1;
                    end
                end
                ST_GEAR3: begin
                    if (btn_pls[BTN_MENU]) begin
                        state_d  = ST_EXIT_WAIT;
                        remain_d = 8'(EXIT_S);
                    end else if (tick) begin
                        if (remain_q <= 8'd1) begin
                            state_d  = ST_GEAR2;
                            remain_d = '0;
                        end else begin
                            remain_d = remain_q - 8'd1;
                        end
                    end
                end
                ST_EXIT_WAIT: begin
                    if (tick) begin
                        if (remain_q <= 8'd1) begin
                            state_d  = ST_STANDBY;
                            remain_d = '0;
                        end else begin
                            remain_d = remain_q - 8'd1;
                        end
                    end
                end
                ST_CLEAN: begin
                    if (tick) begin
                        if (remain_q <= 8'd1) begin
                            state_d  = ST_STANDBY;
                            remain_d = '0;
                            done_d   = 1'b1;
                        end else begin
                            remain_d = remain_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_d  = ST_STANDBY;
                    remain_d = '0;
                end
            endcase
        end

        // Restart the second counter on every state change so the first
        // decrement lands exactly TICK_DIV cycles after entry.
        if (state_d != state_q || tick) tick_cnt_d = '0;
        else                            tick_cnt_d = tick_cnt_q + CW'(1);
    end

    // Output logic: decoded from the next state so outputs flip together
    // with the state register.
    always_comb begin
        mode_d = mode_of(state_d);
        led_d  = led_of(state_d);
        exit_d = (state_d == ST_EXIT_WAIT);
    end

    assign mode_state = mode_q;
    assign exit_wait  = exit_q;
    assign remain_s   = remain_q;
    assign clean_done = done_q;
    assign led        = led_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
module tb_hood_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       machine_state = 1'b0;
    logic [4:0] btns = 5'b0;   // [0] menu [1] mode1 [2] mode2 [3] mode3 [4] clean
    logic [2:0] mode_state;
    logic       exit_wait;
    logic [7:0] remain_s;
    logic       clean_done;
    logic [4:0] led;

    int checks = 0;
    int failures = 0;

    localparam logic [4:0] B_MENU  = 5'b00001;
    localparam logic [4:0] B_MODE1 = 5'b00010;
    localparam logic [4:0] B_MODE2 = 5'b00100;
    localparam logic [4:0] B_MODE3 = 5'b01000;
    localparam logic [4:0] B_CLEAN = 5'b10000;

    hood_mode_ctrl #(
        .TICK_DIV   (4),
        .HURRICANE_S(3),
        .EXIT_S     (2),
        .CLEAN_S    (5)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .machine_state      (machine_state),
        .menu_btn           (btns[0]),
        .mode1_btn          (btns[1]),
        .mode2_btn          (btns[2]),
        .mode3_btn          (btns[3]),
        .mode_self_clean_btn(btns[4]),
        .mode_state         (mode_state),
        .exit_wait          (exit_wait),
        .remain_s           (remain_s),
        .clean_done         (clean_done),
        .led                (led)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leave 3 idle cycles so a prior release is seen, raise the buttons,
    // capture mode_state just before the expected action edge (N+2), and
    // return on the negedge right after the action edge (N+3).
    task press(input logic [4:0] m, output logic [2:0] pre);
        repeat (3) @(negedge clk);
        btns = m;
        repeat (3) @(negedge clk);
        pre = mode_state;
        @(negedge clk);
        btns = 5'b0;
    endtask

    task test_reset;
        logic [2:0] pre;
        rst = 1'b0;
        machine_state = 1'b1;
        idle(3);
        checks++; if (mode_state !== 3'b000) begin failures++; $display("FAIL rst_mode got=%b exp=000", mode_state); end
        checks++; if (led !== 5'b00001) begin failures++; $display("FAIL rst_led got=%b exp=00001", led); end
        checks++; if (remain_s !== 8'd0 || exit_wait !== 1'b0 || clean_done !== 1'b0) begin failures++; $display("FAIL rst_misc got remain=%0d exit=%b done=%b exp 0/0/0", remain_s, exit_wait, clean_done); end
        rst = 1'b1;
        press(B_MENU, pre);
        press(B_MODE2, pre);
        checks++; if (mode_state !== 3'b010) begin failures++; $display("FAIL rst_pre_gear2 got=%b exp=010", mode_state); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mode_state !== 3'b000) begin failures++; $display("FAIL rst_async_mode got=%b exp=000", mode_state); end
        checks++; if (led !== 5'b00001 || remain_s !== 8'd0) begin failures++; $display("FAIL rst_async_led got led=%b remain=%0d exp 00001/0", led, remain_s); end
        @(negedge clk);
        rst = 1'b1;
        press(B_MODE2, pre);
        checks++; if (mode_state !== 3'b000) begin failures++; $display("FAIL rst_unarmed_mode2 got=%b exp=000", mode_state); end
    endtask

    task test_gears;
        logic [2:0] pre;
        press(B_MENU, pre);
        press(B_MODE2, pre);
        checks++; if (pre !== 3'b000) begin failures++; $display("FAIL gear2_latency_early got=%b exp=000", pre); end
        checks++; if (mode_state !== 3'b010 || led !== 5'b00100) begin failures++; $display("FAIL gear2 got mode=%b led=%b exp 010/00100", mode_state, led); end
        press(B_MODE1, pre);
        checks++; if (mode_state !== 3'b001 || led !== 5'b00010) begin failures++; $display("FAIL gear1 got mode=%b led=%b exp 001/00010", mode_state, led); end
        press(B_MENU, pre);
        checks++; if (mode_state !== 3'b000 || led !== 5'b00001) begin failures++; $display("FAIL gear_menu_standby got mode=%b led=%b exp 000/00001", mode_state, led); end
    endtask

    task test_hurricane;
        logic [2:0] pre;
        press(B_MENU, pre);
        press(B_MODE3, pre);
        checks++; if (mode_state !== 3'b011 || led !== 5'b01000 || exit_wait !== 1'b0) begin failures++; $display("FAIL hur_entry got mode=%b led=%b exit=%b exp 011/01000/0", mode_state, led, exit_wait); end
        checks++; if (remain_s !== 8'd3) begin failures++; $display("FAIL hur_remain3 got=%0d exp=3", remain_s); end
        idle(3);
        checks++; if (remain_s !== 8'd3) begin failures++; $display("FAIL hur_remain3_hold got=%0d exp=3", remain_s); end
        idle(1);
        checks++; if (remain_s !== 8'd2) begin failures++; $display("FAIL hur_remain2 got=%0d exp=2", remain_s); end
        idle(4);
        checks++; if (remain_s !== 8'd1) begin failures++; $display("FAIL hur_remain1 got=%0d exp=1", remain_s); end
        idle(3);
        checks++; if (mode_state !== 3'b011) begin failures++; $display("FAIL hur_last_cycle got=%b exp=011", mode_state); end
        idle(1);
        checks++; if (mode_state !== 3'b010 || remain_s !== 8'd0) begin failures++; $display("FAIL hur_drop_gear2 got mode=%b remain=%0d exp 010/0", mode_state, remain_s); end
        press(B_MODE3, pre);
        checks++; if (mode_state !== 3'b010) begin failures++; $display("FAIL hur_used_gear2 got=%b exp=010", mode_state); end
        press(B_MENU, pre);
        press(B_MENU, pre);
        press(B_MODE3, pre);
        checks++; if (mode_state !== 3'b000) begin failures++; $display("FAIL hur_used_standby got=%b exp=000", mode_state); end
        press(B_MODE1, pre);
        checks++; if (mode_state !== 3'b001) begin failures++; $display("FAIL hur_still_armed got=%b exp=001", mode_state); end
        press(B_MENU, pre);
    endtask

    task test_exit_wait;
        logic [2:0] pre;
        machine_state = 1'b0;
        idle(1);
        machine_state = 1'b1;
        press(B_MENU, pre);
        press(B_MODE3, pre);
        checks++; if (mode_state !== 3'b011) begin failures++; $display("FAIL exit_gear3_again got=%b exp=011", mode_state); end
        press(B_MENU, pre);
        checks++; if (exit_wait !== 1'b1 || remain_s !== 8'd2 || mode_state !== 3'b011) begin failures++; $display("FAIL exit_entry got exit=%b remain=%0d mode=%b exp 1/2/011", exit_wait, remain_s, mode_state); end
        idle(4);
        checks++; if (remain_s !== 8'd1) begin failures++; $display("FAIL exit_remain1 got=%0d exp=1", remain_s); end
        idle(3);
        checks++; if (mode_state !== 3'b011 || exit_wait !== 1'b1) begin failures++; $display("FAIL exit_last_cycle got mode=%b exit=%b exp 011/1", mode_state, exit_wait); end
        idle(1);
        checks++; if (mode_state !== 3'b000 || exit_wait !== 1'b0 || led !== 5'b00001 || remain_s !== 8'd0) begin failures++; $display("FAIL exit_done got mode=%b exit=%b led=%b remain=%0d exp 000/0/00001/0", mode_state, exit_wait, led, remain_s); end
    endtask

    task test_clean;
        logic [2:0] pre;
        press(B_MENU, pre);
        press(B_CLEAN, pre);
        checks++; if (mode_state !== 3'b100 || led !== 5'b10000 || remain_s !== 8'd5) begin failures++; $display("FAIL clean_entry got mode=%b led=%b remain=%0d exp 100/10000/5", mode_state, led, remain_s); end
        press(B_MODE1, pre);
        checks++; if (mode_state !== 3'b100) begin failures++; $display("FAIL clean_ignore_mode1 got=%b exp=100", mode_state); end
        press(B_MENU, pre);
        checks++; if (mode_state !== 3'b100 || remain_s !== 8'd2) begin failures++; $display("FAIL clean_ignore_menu got mode=%b remain=%0d exp 100/2", mode_state, remain_s); end
        idle(5);
        checks++; if (remain_s !== 8'd1 || clean_done !== 1'b0 || mode_state !== 3'b100) begin failures++; $display("FAIL clean_last got remain=%0d done=%b mode=%b exp 1/0/100", remain_s, clean_done, mode_state); end
        idle(1);
        checks++; if (mode_state !== 3'b000 || clean_done !== 1'b1 || remain_s !== 8'd0 || led !== 5'b00001) begin failures++; $display("FAIL clean_end got mode=%b done=%b remain=%0d led=%b exp 000/1/0/00001", mode_state, clean_done, remain_s, led); end
        idle(1);
        checks++; if (clean_done !== 1'b0) begin failures++; $display("FAIL clean_done_pulse got=%b exp=0", clean_done); end
    endtask

    task test_back_to_back;
        logic [2:0] pre;
        int done_seen;
        press(B_MENU, pre);
        press(B_MODE2, pre);
        press(B_MENU | B_MODE1, pre);
        checks++; if (pre !== 3'b010 || mode_state !== 3'b000) begin failures++; $display("FAIL prio_menu_mode1 got pre=%b mode=%b exp 010/000", pre, mode_state); end
        press(B_MENU, pre);
        press(B_CLEAN, pre);
        checks++; if (mode_state !== 3'b100) begin failures++; $display("FAIL pwroff_clean_entry got=%b exp=100", mode_state); end
        idle(2);
        machine_state = 1'b0;
        done_seen = 0;
        idle(1);
        checks++; if (mode_state !== 3'b000 || remain_s !== 8'd0 || led !== 5'b00001) begin failures++; $display("FAIL pwroff_standby got mode=%b remain=%0d led=%b exp 000/0/00001", mode_state, remain_s, led); end
        for (int i = 0; i < 25; i++) begin
            if (clean_done === 1'b1) done_seen++;
            @(negedge clk);
        end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL pwroff_no_done got pulses=%0d exp=0", done_seen); end
        machine_state = 1'b1;
        press(B_MENU, pre);
        press(B_MODE3, pre);
        checks++; if (mode_state !== 3'b011 || remain_s !== 8'd3) begin failures++; $display("FAIL pwroff_hur_cleared got mode=%b remain=%0d exp 011/3", mode_state, remain_s); end
    endtask

    initial begin
        test_reset;
        test_gears;
        test_hurricane;
        test_exit_wait;
        test_clean;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
